// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial word comparator: FSM state encoding
// and the helpers that size the result ports from WIDTH.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_e;

  // Bits needed to hold a count of 0..width inclusive (a full match never wraps).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Bits needed to index 0..width-1, at least one bit so WIDTH=1 still has a port.
  function automatic int idx_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/xnor_gate.sv
// Two-input XNOR cell: y is high when a and b agree.
module xnor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  // Bit-equality: the per-bit match term of the comparator.
  assign y = ~(a ^ b);

endmodule

// File: rtl/serial_word_compare.sv
// Serial word comparator: consumes two LSB-first bit streams of WIDTH bits,
// counts matching bit pairs, records the index of the first mismatch and
// reports whole-word equality with a one-cycle done pulse.
//
// Handshake: bit_valid is a valid-only strobe with no ready. A bit pair is
// consumed on every rising edge where the FSM is in SHIFT and bit_valid is
// high; in IDLE and DONE the strobe and its data are dropped. start is a
// request sampled only in IDLE; in SHIFT or DONE it is ignored, never queued.
module serial_word_compare
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               bit_valid,
  input  logic                               a_bit,
  input  logic                               b_bit,
  output logic                               busy,
  output logic                               done,
  output logic                               equal,
  output logic [cnt_width(WIDTH)-1:0]        match_count,
  output logic [idx_width(WIDTH)-1:0]        mismatch_idx,
  output logic [1:0]                         dbg_state
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int IDX_W = idx_width(WIDTH);

  // Index of the final bit of a word, and the count a fully matching word reaches.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  cmp_state_e       state_q, state_d;
  logic [IDX_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic [IDX_W-1:0] mismatch_idx_q, mismatch_idx_d;
  logic             mismatch_seen_q, mismatch_seen_d;
  logic             equal_q, equal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_match;
  logic [CNT_W-1:0] match_inc;
  logic             take_bit;
  logic             last_bit;

  xnor_gate u_xnor (
    .a (a_bit),
    .b (b_bit),
    .y (bit_match)
  );

  assign take_bit  = (state_q == SHIFT) && bit_valid;
  assign last_bit  = (bit_cnt_q == LAST_IDX);
  assign match_inc = match_count_q + CNT_W'(bit_match);

  // FSM state register; reset discards any partial comparison.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus busy/done, which are registered from the next state
  // so the outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (bit_valid && last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // Datapath next values: clear on an accepted start, accumulate on valid bits,
  // hold everywhere else so results persist until the next accepted start.
  always_comb begin
    bit_cnt_d       = bit_cnt_q;
    match_count_d   = match_count_q;
    mismatch_idx_d  = mismatch_idx_q;
    mismatch_seen_d = mismatch_seen_q;
    equal_d         = equal_q;
    if ((state_q == IDLE) && start) begin
      bit_cnt_d       = '0;
      match_count_d   = '0;
      mismatch_idx_d  = '0;
      mismatch_seen_d = 1'b0;
      equal_d         = 1'b0;
    end else if (take_bit) begin
      match_count_d = match_inc;
      bit_cnt_d     = last_bit ? '0 : bit_cnt_q + 1'b1;
      if (!bit_match && !mismatch_seen_q) begin
        mismatch_idx_d  = bit_cnt_q;
        mismatch_seen_d = 1'b1;
      end
      if (last_bit) begin
        equal_d = (match_inc == FULL_CNT);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q       <= '0;
      match_count_q   <= '0;
      mismatch_idx_q  <= '0;
      mismatch_seen_q <= 1'b0;
      equal_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      bit_cnt_q       <= bit_cnt_d;
      match_count_q   <= match_count_d;
      mismatch_idx_q  <= mismatch_idx_d;
      mismatch_seen_q <= mismatch_seen_d;
      equal_q         <= equal_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign equal        = equal_q;
  assign match_count  = match_count_q;
  assign mismatch_idx = mismatch_idx_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_serial_word_compare.sv
// Bench for serial_word_compare at WIDTH=8: directed runs from the
// requirements plus randomized runs, each checked against a word-level model.
module tb_serial_word_compare;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             done;
  logic             equal;
  logic [CNT_W-1:0] match_count;
  logic [IDX_W-1:0] mismatch_idx;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;

  // Expected result words {equal, match_count, mismatch_idx}.
  logic [7:0] exp_q[$];

  logic [7:0] w;
  logic [7:0] ra;
  logic [7:0] rb;

  serial_word_compare #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bit_valid    (bit_valid),
    .a_bit        (a_bit),
    .b_bit        (b_bit),
    .busy         (busy),
    .done         (done),
    .equal        (equal),
    .match_count  (match_count),
    .mismatch_idx (mismatch_idx),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Word-level reference: compare the two words as whole numbers.
  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
    int mc;
    int mi;
    bit found;
    mc = 0;
    mi = 0;
    found = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i] == b[i]) mc++;
      else if (!found) begin
        mi = i;
        found = 1;
      end
    end
    return {(a == b), 4'(mc), 3'(mi)};
  endfunction

  task automatic check_results(input string tag, input logic [7:0] expv);
    check({tag, "_equal"}, equal, expv[7]);
    check({tag, "_match_count"}, match_count, expv[6:3]);
    check({tag, "_mismatch_idx"}, mismatch_idx, expv[2:0]);
  endtask

  // One full comparison. Entered and left at a sampling point (#1 after an
  // edge) with the DUT idle. mode: 0 continuous valid, 1 valid toggling 0/1,
  // 2 random stalls. hold_start keeps start high through the whole run.
  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input int mode,
                         input bit hold_start);
    logic [7:0] expv;
    int idx;
    int k;
    int lat_exp;
    bit v;
    bit seen_done;
    exp_q.push_back(model(a, b));
    start     = 1'b1;
    bit_valid = 1'($urandom_range(0, 1));
    a_bit     = 1'($urandom_range(0, 1));
    b_bit     = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    check("accept_busy", busy, 1);
    check("accept_done", done, 0);
    check("accept_match_count", match_count, 0);
    check("accept_mismatch_idx", mismatch_idx, 0);
    start     = hold_start;
    idx       = 0;
    k         = 0;
    lat_exp   = 0;
    seen_done = 0;
    while (!seen_done && k < 200) begin
      k++;
      case (mode)
        0:       v = 1'b1;
        1:       v = ((k % 2) == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bit_valid = v;
      if (v && idx < WIDTH) begin
        a_bit = a[idx];
        b_bit = b[idx];
        idx++;
        if (idx == WIDTH) lat_exp = k;
      end else begin
        a_bit = 1'($urandom_range(0, 1));
        b_bit = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1;
      else if (idx < WIDTH) check("shift_busy", busy, 1);
    end
    check("done_seen", seen_done, 1);
    check("done_latency", k, lat_exp);
    expv = exp_q.pop_front();
    check("done_busy", busy, 0);
    check_results("done", expv);
    // DONE lasts one cycle; valid bits and start there are ignored.
    bit_valid = 1'b1;
    a_bit     = ~a[0];
    b_bit     = a[0];
    start     = 1'b1;
    @(posedge clk); #1;
    start = hold_start;
    check("after_done_pulse", done, 0);
    check("after_done_busy", busy, 0);
    check_results("after_done", expv);
    if (!hold_start) begin
      repeat (3) begin
        bit_valid = 1'($urandom_range(0, 1));
        a_bit     = 1'($urandom_range(0, 1));
        b_bit     = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check_results("idle_hold", expv);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    bit_valid = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_equal", equal, 0);
    check("reset_match_count", match_count, 0);
    check("reset_mismatch_idx", mismatch_idx, 0);
    rst_n = 1'b1;

    // bit_valid without start must not start anything.
    bit_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_no_start_busy", busy, 0);
      check("idle_no_start_count", match_count, 0);
    end

    // Directed runs.
    run_cmp(8'hA5, 8'hA5, 0, 1'b0);
    run_cmp(8'hA5, 8'hA4, 0, 1'b0);
    run_cmp(8'h0F, 8'h8F, 0, 1'b0);
    run_cmp(8'h00, 8'hFF, 1, 1'b0);

    // Reset after four valid bits of a run.
    w     = 8'h3C;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      a_bit     = w[i];
      b_bit     = w[i];
      @(posedge clk); #1;
      check("pre_reset_busy", busy, 1);
    end
    check("pre_reset_match_count", match_count, 4);
    rst_n     = 1'b0;
    bit_valid = 1'b1;
    a_bit     = w[4];
    b_bit     = w[4];
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_equal", equal, 0);
    check("mid_reset_match_count", match_count, 0);
    check("mid_reset_mismatch_idx", mismatch_idx, 0);
    for (int i = 0; i < 12; i++) begin
      bit_valid = 1'b1;
      a_bit     = 1'($urandom_range(0, 1));
      b_bit     = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("post_reset_no_done", done, 0);
      check("post_reset_idle", busy, 0);
    end
    run_cmp(8'h3C, 8'h3C, 0, 1'b0);

    // start held high across back-to-back runs.
    ra = 8'($urandom);
    rb = 8'($urandom);
    run_cmp(ra, rb, 0, 1'b1);
    ra = 8'($urandom);
    run_cmp(ra, ra, 2, 1'b1);
    ra = 8'($urandom);
    rb = ra ^ 8'h80;
    run_cmp(ra, rb, 2, 1'b0);

    // Randomized runs with random stalls; some words forced equal.
    for (int n = 0; n < 10; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      run_cmp(ra, rb, 2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
